// File: rtl/vec_pkg.sv
// Shared widths, row type and writer FSM state encoding for the vector datapath.
`timescale 1ns/1ps
package vec_pkg;
    localparam int ELEM_WIDTH = 32;
    localparam int VEC_COUNT  = 4;
    localparam int VLEN       = ELEM_WIDTH * VEC_COUNT;

    typedef logic [VLEN-1:0] vec_row_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wr_state_e;
endpackage

// File: rtl/vec_result_writer.sv
// Captures one VALU result and streams its rows into the result RAM, one per accepted beat.
// Optional XOR checksum output is enabled by defining VEC_RESULT_WRITER_CHECKSUM_EN.
`timescale 1ns/1ps
module vec_result_writer #(
    parameter int ELEM_WIDTH = vec_pkg::ELEM_WIDTH,
    parameter int VEC_COUNT  = vec_pkg::VEC_COUNT,
    parameter int VLEN       = ELEM_WIDTH * VEC_COUNT,
    parameter int ADDR_W     = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [VLEN-1:0]   result [VEC_COUNT],
    input  logic [ADDR_W-1:0] base_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [VLEN-1:0]   wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done
`ifdef VEC_RESULT_WRITER_CHECKSUM_EN
    ,
    output logic [VLEN-1:0]   checksum
`endif
);
    import vec_pkg::*;

    localparam int ROW_W = $clog2(VEC_COUNT + 1);
    localparam int IDX_W = (VEC_COUNT > 1) ? $clog2(VEC_COUNT) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(VEC_COUNT - 1);

    wr_state_e         state;
    wr_state_e         state_nxt;
    logic [VLEN-1:0]   row_buf [VEC_COUNT];
    logic [ADDR_W-1:0] base_q;
    logic [ROW_W-1:0]  row;
    logic [ROW_W-1:0]  row_nxt;

    logic              capture;
    logic              accept;
    logic              last_beat;

    logic              res_ready_nxt;
    logic              wr_en_nxt;
    logic [ADDR_W-1:0] wr_addr_nxt;
    logic [VLEN-1:0]   wr_data_nxt;
    logic              busy_nxt;
    logic              done_nxt;

    assign capture   = (state == IDLE) && res_valid;
    assign accept    = (state == WRITE) && wr_en && wr_ready;
    assign last_beat = accept && (row == LAST_ROW);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (res_valid) state_nxt = WRITE;
            WRITE:   if (last_beat) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; the first beat comes straight from the
    // input rows because the buffer is only loaded on the same edge.
    always_comb begin
        row_nxt       = row;
        res_ready_nxt = res_ready;
        wr_en_nxt     = wr_en;
        wr_addr_nxt   = wr_addr;
        wr_data_nxt   = wr_data;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (res_valid) begin
                    res_ready_nxt = 1'b0;
                    wr_en_nxt     = 1'b1;
                    busy_nxt      = 1'b1;
                    row_nxt       = '0;
                    wr_addr_nxt   = base_addr;
                    wr_data_nxt   = result[0];
                end
            end
            WRITE: begin
                if (last_beat) begin
                    wr_en_nxt = 1'b0;
                    done_nxt  = 1'b1;
                end else if (accept) begin
                    row_nxt     = row + ROW_W'(1);
                    wr_addr_nxt = base_q + ADDR_W'(row_nxt);
                    wr_data_nxt = row_buf[IDX_W'(row_nxt)];
                end
            end
            DONE: begin
                res_ready_nxt = 1'b1;
                busy_nxt      = 1'b0;
            end
            default: begin
                res_ready_nxt = 1'b1;
                wr_en_nxt     = 1'b0;
                busy_nxt      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row       <= '0;
            base_q    <= '0;
            res_ready <= 1'b1;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < VEC_COUNT; i++) begin
                row_buf[i] <= '0;
            end
        end else begin
            row       <= row_nxt;
            res_ready <= res_ready_nxt;
            wr_en     <= wr_en_nxt;
            wr_addr   <= wr_addr_nxt;
            wr_data   <= wr_data_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            if (capture) begin
                base_q <= base_addr;
                for (int i = 0; i < VEC_COUNT; i++) begin
                    row_buf[i] <= result[i];
                end
            end
        end
    end

`ifdef VEC_RESULT_WRITER_CHECKSUM_EN
    // Held after the last beat so it reads stable from the done cycle until the next capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if (capture) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum ^ wr_data;
        end
    end
`else
    // No checksum accumulator in this build.
`endif

endmodule

// File: tb/tb_vec_result_writer.sv
// Scoreboard bench for vec_result_writer: stimulus pushes expected beats/done, a monitor pops and compares.
`timescale 1ns/1ps
module tb_vec_result_writer;
    import vec_pkg::*;

    localparam int ADDR_W = 5;

    logic              clk       = 1'b0;
    logic              reset_n   = 1'b0;
    logic              res_valid = 1'b0;
    logic              res_ready;
    vec_row_t          result [VEC_COUNT];
    logic [ADDR_W-1:0] base_addr = '0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    vec_row_t          wr_data;
    logic              wr_ready  = 1'b1;
    logic              busy;
    logic              done;
`ifdef VEC_RESULT_WRITER_CHECKSUM_EN
    vec_row_t          checksum;
`endif

    vec_result_writer #(
        .ELEM_WIDTH(ELEM_WIDTH),
        .VEC_COUNT (VEC_COUNT),
        .VLEN      (VLEN),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .result   (result),
        .base_addr(base_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .busy     (busy),
        .done     (done)
`ifdef VEC_RESULT_WRITER_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        vec_row_t          data;
    } beat_t;

    typedef struct {
        int       cyc;
        vec_row_t csum;
    } done_t;

    beat_t    beat_q [$];
    done_t    done_q [$];
    vec_row_t rows_v [VEC_COUNT];

    int checks = 0;
    int errors = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checka(input string name, input logic [ADDR_W-1:0] act, input logic [ADDR_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkv(input string name, input vec_row_t act, input vec_row_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check1({tag, "_res_ready"}, res_ready, 1'b1);
        check1({tag, "_wr_en"}, wr_en, 1'b0);
        checka({tag, "_wr_addr"}, wr_addr, '0);
        checkv({tag, "_wr_data"}, wr_data, '0);
        check1({tag, "_busy"}, busy, 1'b0);
        check1({tag, "_done"}, done, 1'b0);
`ifdef VEC_RESULT_WRITER_CHECKSUM_EN
        checkv({tag, "_checksum"}, checksum, '0);
`endif
    endtask

    // Presents rows_v at base; returns c0, the cycle in which beat 0 is visible.
    task automatic send(input logic [ADDR_W-1:0] base, input int stalls, input vec_row_t csum, output int c0);
        beat_t b;
        done_t d;
        @(negedge clk);
        check1("res_ready_before_send", res_ready, 1'b1);
        for (int i = 0; i < VEC_COUNT; i++) begin
            result[i] = rows_v[i];
            b.addr    = base + ADDR_W'(i);
            b.data    = rows_v[i];
            beat_q.push_back(b);
        end
        base_addr = base;
        res_valid = 1'b1;
        @(posedge clk);
        #1;
        c0        = cyc;
        res_valid = 1'b0;
        d.cyc     = c0 + VEC_COUNT + stalls;
        d.csum    = csum;
        done_q.push_back(d);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(res_ready && beat_q.size() == 0 && done_q.size() == 0) && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL %s_timeout: %0d beats and %0d done pending after %0d cycles", name, beat_q.size(), done_q.size(), n);
        end
    endtask

    // Monitor: every presented beat must match the head of the queue; it pops only when accepted.
    initial begin
        done_t d;
        forever begin
            @(negedge clk);
            #1;
            if (wr_en) begin
                if (beat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: addr %0d data %h with none pending", wr_addr, wr_data);
                end else begin
                    checka("beat_addr", wr_addr, beat_q[0].addr);
                    checkv("beat_data", wr_data, beat_q[0].data);
                    if (wr_ready) void'(beat_q.pop_front());
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
                end else begin
                    d = done_q.pop_front();
                    checki("done_cycle", cyc, d.cyc);
`ifdef VEC_RESULT_WRITER_CHECKSUM_EN
                    checkv("checksum", checksum, d.csum);
`endif
                end
            end
        end
    end

    initial begin
        int c0;
        for (int i = 0; i < VEC_COUNT; i++) begin
            result[i] = '0;
            rows_v[i] = '0;
        end
        #12;
        check_reset("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Basic write with exact cycle positions
        rows_v[0] = {16{8'h11}};
        rows_v[1] = {16{8'h22}};
        rows_v[2] = {16{8'h33}};
        rows_v[3] = {16{8'h44}};
        send(5'd4, 0, {16{8'h44}}, c0);
        wait_cyc(c0);
        check1("basic_busy", busy, 1'b1);
        check1("basic_ready_low", res_ready, 1'b0);
        wait_cyc(c0 + 4);
        check1("basic_done_pulse", done, 1'b1);
        check1("basic_ready_in_done", res_ready, 1'b0);
        wait_cyc(c0 + 5);
        check1("basic_ready_back", res_ready, 1'b1);
        check1("basic_done_gone", done, 1'b0);
        check1("basic_busy_gone", busy, 1'b0);
        wait_idle("basic");

        // Address wrap
        rows_v[0] = {16{8'h01}};
        rows_v[1] = {16{8'h02}};
        rows_v[2] = {16{8'h03}};
        rows_v[3] = {16{8'h04}};
        send(5'd30, 0, {16{8'h04}}, c0);
        wait_idle("wrap");

        // Backpressure on beat 1 for three cycles
        rows_v[0] = {16{8'h10}};
        rows_v[1] = {16{8'h20}};
        rows_v[2] = {16{8'h40}};
        rows_v[3] = {16{8'h80}};
        send(5'd10, 3, {16{8'hF0}}, c0);
        @(negedge clk);
        @(negedge clk);
        wr_ready = 1'b0;
        repeat (3) @(negedge clk);
        wr_ready = 1'b1;
        wait_idle("backpressure");

        // A second result offered mid-write is ignored
        rows_v[0] = {16{8'h5A}};
        rows_v[1] = {16{8'hA5}};
        rows_v[2] = {16{8'h0F}};
        rows_v[3] = {16{8'hF0}};
        send(5'd0, 0, '0, c0);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < VEC_COUNT; i++) result[i] = ~rows_v[i];
        base_addr = 5'd31;
        res_valid = 1'b1;
        #1;
        check1("ignore_ready_low", res_ready, 1'b0);
        @(negedge clk);
        res_valid = 1'b0;
        wait_idle("ignore");

        // Reset after two beats are written, then a clean transfer
        rows_v[0] = {16{8'h66}};
        rows_v[1] = {16{8'h77}};
        rows_v[2] = {16{8'h88}};
        rows_v[3] = {16{8'h99}};
        send(5'd20, 0, '0, c0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        beat_q.delete();
        done_q.delete();
        #1;
        check_reset("midreset");
        repeat (2) @(negedge clk);
        #1;
        check1("midreset_hold_wr_en", wr_en, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        rows_v[0] = {16{8'h01}};
        rows_v[1] = {16{8'h02}};
        rows_v[2] = {16{8'h03}};
        rows_v[3] = {16{8'h04}};
        send(5'd3, 0, {16{8'h04}}, c0);
        wait_idle("after_reset");

        // Single-bit rows: checksum 0xF
        rows_v[0] = 128'h1;
        rows_v[1] = 128'h2;
        rows_v[2] = 128'h4;
        rows_v[3] = 128'h8;
        send(5'd0, 0, 128'hF, c0);
        wait_idle("onehot");

        repeat (3) @(negedge clk);
        #1;
        checki("beats_left", beat_q.size(), 0);
        checki("done_left", done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
